// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: packs 32-bit pixels into 64-bit SDRAM words and writes them over Avalon-MM; FB_WRITER_STATS_EN adds debug counters
module fb_pixel_writer #(
  parameter int unsigned ADDRESS    = 0,
  parameter int unsigned LENGTH     = 0,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned IDLE_FLUSH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [23:0] pix_index,
  input  logic [31:0] pix_data,
  input  logic        pix_buffer,
  input  logic        flush_req,
  output logic        flush_done,
  output logic [28:0] address,
  output logic [7:0]  burstcount,
  output logic        write,
  output logic [63:0] writedata,
  output logic [7:0]  byteenable,
  input  logic        waitrequest
`ifdef FB_WRITER_STATS_EN
  ,
  output logic [31:0] debug_value0,
  output logic [31:0] debug_value1,
  output logic [31:0] debug_value2
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(IDLE_FLUSH + 2);
  localparam logic [28:0] BASE0 = 29'(ADDRESS / 8);
  localparam logic [28:0] BASE1 = BASE0 + 29'(LENGTH / 8);
  localparam logic [31:0] LIMIT = 32'(LENGTH / 4);
  typedef struct packed {
    logic [28:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } entry_t;
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state, state_nx;
  entry_t pend, head;
  entry_t mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] idle_cnt;
  logic [28:0] pix_addr;
  logic [63:0] merged;
  logic [7:0] pix_be;
  logic p_valid, rdy_en, flushing, fifo_empty, fifo_full;
  logic accept, in_range, take, same, push, pop, done_cond;
  assign burstcount = 8'h01;
  // handshake, address/lane formation, merge data and FIFO control
  always_comb begin
    fifo_empty = wr_ptr == rd_ptr;
    fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    pix_ready  = rdy_en && !flushing && !(p_valid && fifo_full);
    accept     = pix_valid && pix_ready;
    in_range   = {8'h00, pix_index} < LIMIT;
    take       = accept && in_range;
    pix_addr   = (pix_buffer ? BASE1 : BASE0) + 29'(pix_index[23:1]);
    pix_be     = pix_index[0] ? 8'hF0 : 8'h0F;
    merged     = pix_index[0] ? {pix_data, pend.data[31:0]} : {pend.data[63:32], pix_data};
    same       = p_valid && pend.addr == pix_addr;
    push       = take ? p_valid && !same
                      : p_valid && !fifo_full && (pend.be == 8'hFF || idle_cnt == IW'(IDLE_FLUSH) || flushing);
    pop        = !fifo_empty && (state == IDLE || !waitrequest);
    head       = mem[rd_ptr[AW-1:0]];
    done_cond  = (flushing || flush_req) && !take && !p_valid && fifo_empty && !(write && waitrequest);
    state_nx   = pop ? WRITE : (!waitrequest ? IDLE : state);
  end
  // pending word: load, merge, or hand off to the FIFO
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_valid <= 1'b0;
      pend    <= '0;
    end else if (take) begin
      p_valid <= 1'b1;
      pend    <= same ? {pend.addr, merged, pend.be | pix_be} : {pix_addr, {pix_data, pix_data}, pix_be};
    end else if (push) begin
      p_valid <= 1'b0;
    end
  end
  // FIFO storage needs no reset; the pointers define what is valid
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= pend;
  end
  // FIFO pointers, idle timer, ready enable and flush tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      idle_cnt   <= '0;
      rdy_en     <= 1'b0;
      flushing   <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(push);
      rd_ptr     <= rd_ptr + PW'(pop);
      idle_cnt   <= accept ? '0 : (idle_cnt == IW'(IDLE_FLUSH) ? idle_cnt : idle_cnt + 1'b1);
      rdy_en     <= 1'b1;
      flushing   <= done_cond ? 1'b0 : (flush_req ? 1'b1 : flushing);
      flush_done <= done_cond;
    end
  end
  // write master: registered Avalon outputs held stable while stalled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
    end else begin
      state <= state_nx;
      if (pop) begin
        {address, writedata, byteenable} <= head;
        write <= 1'b1;
      end else if (!waitrequest) begin
        write <= 1'b0;
      end
    end
  end
`ifdef FB_WRITER_STATS_EN
  // saturating event counters, cleared at the end of each flush
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      debug_value0 <= '0;
      debug_value1 <= '0;
      debug_value2 <= '0;
    end else if (flush_done) begin
      debug_value0 <= '0;
      debug_value1 <= '0;
      debug_value2 <= '0;
    end else begin
      debug_value0 <= debug_value0 + 32'(write && !waitrequest && ~&debug_value0);
      debug_value1 <= debug_value1 + 32'(take && same && ~&debug_value1);
      debug_value2 <= debug_value2 + 32'(accept && !in_range && ~&debug_value2);
    end
  end
`endif
endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer: directed vector and sequence bench for fb_pixel_writer
module tb_fb_pixel_writer;
  logic clock = 1'b0, reset = 1'b1;
  logic pix_valid = 1'b0, pix_buffer = 1'b0, flush_req = 1'b0, waitrequest = 1'b0;
  logic [23:0] pix_index = '0;
  logic [31:0] pix_data = '0;
  logic pix_ready, flush_done, write;
  logic [28:0] address;
  logic [7:0] burstcount, byteenable;
  logic [63:0] writedata;
`ifdef FB_WRITER_STATS_EN
  logic [31:0] dv0, dv1, dv2;
`endif
  fb_pixel_writer #(.ADDRESS(32'h1000), .LENGTH(32'h100000), .FIFO_DEPTH(16), .IDLE_FLUSH(4)) dut (
    .clock(clock), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_index(pix_index), .pix_data(pix_data), .pix_buffer(pix_buffer),
    .flush_req(flush_req), .flush_done(flush_done), .address(address),
    .burstcount(burstcount), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest)
`ifdef FB_WRITER_STATS_EN
    , .debug_value0(dv0), .debug_value1(dv1), .debug_value2(dv2)
`endif
  );
  always #5 clock = ~clock;
  typedef struct packed {
    logic [28:0] a;
    logic [63:0] d;
    logic [7:0]  e;
  } wr_t;
  typedef struct {
    logic [23:0] i0; logic b0; logic [31:0] d0;
    logic has1; logic [23:0] i1; logic b1; logic [31:0] d1;
    int nw;
    logic [28:0] a0; logic [63:0] w0; logic [7:0] e0;
    logic [28:0] a1; logic [63:0] w1; logic [7:0] e1;
  } vec_t;
  wr_t wq[$];
  wr_t prev;
  vec_t vt[7];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_wr = 0, done_cyc = 0, done_cnt = 0, hold_err = 0;
  int acc, acc_r, ready_err, d0, c0;
  logic prev_stall = 1'b0, seen;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (write && !waitrequest) begin
      wq.push_back({address, writedata, byteenable});
      last_wr <= cyc;
    end
    if (flush_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (write && waitrequest && prev_stall && {address, writedata, byteenable} != prev) hold_err <= hold_err + 1;
    prev_stall <= write && waitrequest;
    prev <= {address, writedata, byteenable};
  end
  function automatic logic [63:0] msk(input logic [7:0] be);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [23:0] i, input logic b, input logic [31:0] d, input logic fr);
    logic ok;
    ok = 1'b0;
    pix_valid = 1'b1; pix_index = i; pix_buffer = b; pix_data = d; flush_req = fr;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clock);
      ok = pix_ready;
      @(posedge clock);
      #1;
      flush_req = 1'b0;
    end
    pix_valid = 1'b0;
    check($sformatf("send_accept_idx%0h", i), 64'(ok), 64'd1);
  endtask
  task automatic check_wr(input string name, input int k, input logic [28:0] a, input logic [63:0] w, input logic [7:0] e);
    wr_t x;
    x = (wq.size() > k) ? wq[k] : '0;
    check({name, "_addr"}, 64'(x.a), 64'(a));
    check({name, "_be"}, 64'(x.e), 64'(e));
    check({name, "_data"}, x.d & msk(e), w & msk(e));
  endtask
  initial begin
    vt[0] = '{24'd0, 0, 32'h00AABBCC, 1, 24'd1, 0, 32'h00112233, 1,
              29'h200, 64'h00112233_00AABBCC, 8'hFF, 29'h0, 64'h0, 8'h0};
    vt[1] = '{24'd5, 1, 32'h00000042, 0, 24'd0, 0, 32'h0, 1,
              29'h20202, 64'h00000042_00000000, 8'hF0, 29'h0, 64'h0, 8'h0};
    vt[2] = '{24'd2, 0, 32'h00000011, 1, 24'd4, 0, 32'h00000022, 2,
              29'h201, 64'h00000000_00000011, 8'h0F, 29'h202, 64'h00000000_00000022, 8'h0F};
    vt[3] = '{24'd2, 0, 32'h0000000A, 1, 24'd2, 0, 32'h0000000B, 1,
              29'h201, 64'h00000000_0000000B, 8'h0F, 29'h0, 64'h0, 8'h0};
    vt[4] = '{24'd3, 0, 32'h00000033, 1, 24'd2, 0, 32'h00000022, 1,
              29'h201, 64'h00000033_00000022, 8'hFF, 29'h0, 64'h0, 8'h0};
    vt[5] = '{24'h040000, 0, 32'h00000099, 1, 24'h03FFFF, 0, 32'h00000077, 1,
              29'h201FF, 64'h00000077_00000000, 8'hF0, 29'h0, 64'h0, 8'h0};
    vt[6] = '{24'd7, 1, 32'h00000055, 1, 24'd7, 0, 32'h00000066, 2,
              29'h20203, 64'h00000055_00000000, 8'hF0, 29'h203, 64'h00000066_00000000, 8'hF0};
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_write", 64'(write), 64'd0);
    check("rst_ready", 64'(pix_ready), 64'd0);
    check("rst_address", 64'(address), 64'd0);
    check("rst_writedata", writedata, 64'd0);
    check("rst_byteenable", 64'(byteenable), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    check("burstcount", 64'(burstcount), 64'd1);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("ready_before_edge", 64'(pix_ready), 64'd0);
    @(negedge clock);
    check("ready_after_release", 64'(pix_ready), 64'd1);
    @(posedge clock);
    #1;
    for (int v = 0; v < 7; v++) begin
      wq.delete();
      send(vt[v].i0, vt[v].b0, vt[v].d0, 1'b0);
      if (vt[v].has1) send(vt[v].i1, vt[v].b1, vt[v].d1, 1'b0);
      repeat (15) @(posedge clock);
      #1;
      check($sformatf("v%0d_count", v), 64'(wq.size()), 64'(vt[v].nw));
      if (vt[v].nw > 0) check_wr($sformatf("v%0d_w0", v), 0, vt[v].a0, vt[v].w0, vt[v].e0);
      if (vt[v].nw > 1) check_wr($sformatf("v%0d_w1", v), 1, vt[v].a1, vt[v].w1, vt[v].e1);
    end
`ifdef FB_WRITER_STATS_EN
    check("stats_writes", 64'(dv0), 64'd9);
    check("stats_merges", 64'(dv1), 64'd3);
    check("stats_drops", 64'(dv2), 64'd1);
`endif
    wq.delete();
    waitrequest = 1'b1;
    acc = 0;
    acc_r = 0;
    fork
      begin
        repeat (40) @(posedge clock);
        acc_r = acc;
        #1 waitrequest = 1'b0;
      end
    join_none
    for (int k = 0; k < 40; k++) begin
      send(24'(k), 1'b0, 32'(k), 1'b0);
      acc++;
    end
    repeat (40) @(posedge clock);
    #1;
    check("bp_accepted_when_full", 64'(acc_r), 64'd35);
    check("bp_count", 64'(wq.size()), 64'd20);
    check("bp_hold_stable", 64'(hold_err), 64'd0);
    for (int k = 0; k < 20; k++)
      check_wr($sformatf("bp_w%0d", k), k, 29'h200 + 29'(k), {32'(2*k+1), 32'(2*k)}, 8'hFF);
    wq.delete();
    d0 = done_cnt;
    send(24'd10, 1'b0, 32'h000000A1, 1'b0);
    send(24'd100, 1'b0, 32'h000000B2, 1'b0);
    send(24'd1000, 1'b0, 32'h000000C3, 1'b0);
    flush_req = 1'b1;
    @(posedge clock);
    #1 flush_req = 1'b0;
    seen = 1'b0;
    ready_err = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clock);
      if (flush_done) seen = 1'b1;
      else if (pix_ready) ready_err++;
    end
    @(posedge clock);
    #1;
    repeat (5) @(posedge clock);
    #1;
    check("fl_done_seen", 64'(seen), 64'd1);
    check("fl_ready_low", 64'(ready_err), 64'd0);
    check("fl_count", 64'(wq.size()), 64'd3);
    check_wr("fl_w0", 0, 29'h205, 64'h000000A1, 8'h0F);
    check_wr("fl_w1", 1, 29'h232, 64'h000000B2, 8'h0F);
    check_wr("fl_w2", 2, 29'h3F4, 64'h000000C3, 8'h0F);
    check("fl_done_timing", 64'(done_cyc), 64'(last_wr + 1));
    check("fl_done_once", 64'(done_cnt - d0), 64'd1);
`ifdef FB_WRITER_STATS_EN
    check("stats_cleared", 64'(dv0), 64'd0);
`endif
    flush_req = 1'b1;
    c0 = cyc;
    @(posedge clock);
    #1 flush_req = 1'b0;
    @(negedge clock);
    check("empty_flush_done", 64'(flush_done), 64'd1);
    check("empty_flush_cycle", 64'(cyc), 64'(c0 + 1));
    @(negedge clock);
    check("empty_flush_pulse", 64'(flush_done), 64'd0);
    @(posedge clock);
    #1;
    wq.delete();
    d0 = done_cnt;
    send(24'd20, 1'b0, 32'h000000D4, 1'b1);
    repeat (20) @(posedge clock);
    #1;
    check("sim_count", 64'(wq.size()), 64'd1);
    check_wr("sim_w0", 0, 29'h20A, 64'h000000D4, 8'h0F);
    check("sim_done_once", 64'(done_cnt - d0), 64'd1);
    check("sim_done_after_write", 64'(done_cyc), 64'(last_wr + 1));
    wq.delete();
    waitrequest = 1'b1;
    send(24'd0, 1'b0, 32'h1, 1'b0);
    send(24'd2, 1'b0, 32'h2, 1'b0);
    send(24'd4, 1'b0, 32'h3, 1'b0);
    for (int t = 0; t < 50; t++) begin
      if (write) break;
      @(negedge clock);
    end
    check("mid_write_seen", 64'(write), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_write", 64'(write), 64'd0);
    check("mid_reset_ready", 64'(pix_ready), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    wq.delete();
    reset = 1'b0;
    waitrequest = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    check("post_reset_no_writes", 64'(wq.size()), 64'd0);
    send(24'd6, 1'b0, 32'h000000E5, 1'b0);
    repeat (15) @(posedge clock);
    #1;
    check("post_reset_count", 64'(wq.size()), 64'd1);
    check_wr("post_reset_w0", 0, 29'h203, 64'h000000E5, 8'h0F);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
